// File: rtl/reg_rd_ctrl.sv
// Register-read sequencer: accepts one request at a time, drives the bank's shared
// read-enable/address for RD_LAT+1 cycles, and returns the captured data with parity.
module reg_rd_ctrl #(
   parameter int DW     = 8,
   parameter int AW     = 8,
   parameter int RD_LAT = 0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   input  logic          i_rd_req,
   input  logic [AW-1:0] i_rd_addr,
   output logic          o_rd_ack,
   output logic          o_ren,
   output logic [AW-1:0] o_addr,
   input  logic [DW-1:0] i_rdata,
   output logic          o_rsp_vld,
   output logic [DW-1:0] o_rsp_data,
   output logic          o_rsp_par,
   input  logic          i_rsp_rdy,
   output logic          o_busy,
   output logic [15:0]   o_rd_cnt
);
   // state | meaning
   // IDLE  | no request in flight; o_rd_ack follows i_rd_req
   // ISSUE | first ren cycle; data captured here when RD_LAT=0
   // WAIT  | additional ren cycles while the bank settles
   // RESP  | response valid, held until i_rsp_rdy
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] WAIT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          par_q, par_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic          capture;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wcnt_d   = wcnt_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      o_rd_ack = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_rd_ack = i_rd_req & ~i_flush;
            if (o_rd_ack) begin
               addr_d  = i_rd_addr;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (RD_LAT == 0) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else begin
               wcnt_d  = WAIT_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wcnt_q == 2'd0) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else begin
               wcnt_d = wcnt_q - 2'd1;
            end
         end
         S_RESP: begin
            if (i_rsp_rdy) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything: no capture, no count, data and address kept.
      if (i_flush) begin
         state_d = S_IDLE;
         capture = 1'b0;
         cnt_d   = cnt_q;
      end
   end

   assign data_d = capture ? i_rdata : data_q;
   assign par_d  = capture ? ^i_rdata : par_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         cnt_q   <= 16'd0;
         wcnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign o_ren      = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign o_rsp_vld  = (state_q == S_RESP);
   assign o_busy     = (state_q != S_IDLE);
   assign o_addr     = addr_q;
   assign o_rsp_data = data_q;
   assign o_rsp_par  = par_q;
   assign o_rd_cnt   = cnt_q;

endmodule
